// File: rtl/organ_pkg.sv
// Shared types and constants for the organ note path: note encoding,
// sequencer mode encoding and the default beat length used by the
// sequencer and the tone generator.
package organ_pkg;

    localparam int NOTE_BITS = 3;

    typedef logic [NOTE_BITS-1:0] note_t;

    // Code 0 means no key pressed / silence.
    localparam note_t NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECORD = 2'd1,
        PLAY   = 2'd2
    } seq_mode_e;

    // One beat at the board clock rate.
    localparam int TICK_DIV_DEFAULT = 12500000;

endpackage

// File: rtl/melody_sequencer_if.sv
// Command/status bundle between the keyboard-side controller and the
// melody sequencer. master = command source, slave = sequencer.
interface melody_sequencer_if #(
    parameter int NOTE_W = 3,
    parameter int DEPTH  = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rec_start;
    logic              play_start;
    logic              stop;
    logic [NOTE_W-1:0] key_value;

    logic              state;
    logic [NOTE_W-1:0] value_play;
    logic              rec_active;
    logic [CNT_W-1:0]  count;
    logic              full;

    modport master (
        output rec_start, play_start, stop, key_value,
        input  state, value_play, rec_active, count, full
    );

    modport slave (
        input  rec_start, play_start, stop, key_value,
        output state, value_play, rec_active, count, full
    );

endinterface

// File: rtl/beat_timer.sv
// Beat timer: counts TICK_DIV cycles per beat while enabled and flags
// the last cycle of each beat. Held at zero when disabled or cleared.
module beat_timer #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic beat_end
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign beat_end = en && (cnt_q == LAST);

    // Next count: clear/disable force zero, otherwise wrap at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en)
            cnt_d = '0;
        else if (cnt_q == LAST)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody record/playback controller. Records distinct key presses into a
// small register buffer and replays them one note per beat, driving the
// play/input select and the played note to the display and tone blocks.
// Build option: define MELODY_LOOP_EN to repeat the melody until stopped
// instead of a single pass.
module melody_sequencer
    import organ_pkg::*;
#(
    parameter int DEPTH    = 32,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int NOTE_W   = NOTE_BITS
) (
    input logic               clk,
    input logic               rst,
    melody_sequencer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_RECORD = RECORD;
    localparam logic [1:0] S_PLAY   = PLAY;

    logic [1:0]        mode_q, mode_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NOTE_W-1:0] vp_q, vp_d;
    logic [NOTE_W-1:0] key_prev_q;
    logic [NOTE_W-1:0] mem_q [DEPTH];

    logic          press;
    logic          full;
    logic          last_note;
    logic          wr_en;
    logic          restart;
    logic          beat_end;
    logic [PW-1:0] ptr_inc;

    // A press is a new non-rest code; holding a key never re-triggers.
    assign press     = (bus.key_value != '0) && (bus.key_value != key_prev_q);
    assign full      = (count_q == CW'(DEPTH));
    assign last_note = ({1'b0, ptr_q} == (count_q - CW'(1)));
    assign ptr_inc   = ptr_q + PW'(1);

    beat_timer #(.TICK_DIV(TICK_DIV)) u_beat (
        .clk      (clk),
        .rst      (rst),
        .en       (mode_q == S_PLAY),
        .clr      (restart || (mode_d != S_PLAY)),
        .beat_end (beat_end)
    );

    // Mode transitions and datapath next-state; stop > rec_start > play_start.
    always_comb begin
        mode_d  = mode_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        vp_d    = vp_q;
        wr_en   = 1'b0;
        restart = 1'b0;
        case (mode_q)
            S_IDLE: begin
                if (bus.stop) begin
                    mode_d = S_IDLE;
                end else if (bus.rec_start) begin
                    mode_d  = S_RECORD;
                    count_d = '0;
                end else if (bus.play_start && (count_q != '0)) begin
                    mode_d  = S_PLAY;
                    restart = 1'b1;
                    ptr_d   = '0;
                    vp_d    = mem_q[0];
                end
            end
            S_RECORD: begin
                if (bus.stop) begin
                    mode_d = S_IDLE;
                end else if (bus.rec_start) begin
                    count_d = '0;
                end else if (press && !full) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            S_PLAY: begin
                if (bus.stop) begin
                    mode_d = S_IDLE;
                    vp_d   = NOTE_W'(NOTE_REST);
                end else if (bus.rec_start) begin
                    mode_d  = S_RECORD;
                    count_d = '0;
                    vp_d    = NOTE_W'(NOTE_REST);
                end else if (bus.play_start) begin
                    restart = 1'b1;
                    ptr_d   = '0;
                    vp_d    = mem_q[0];
                end else if (beat_end) begin
                    if (last_note) begin
`ifdef MELODY_LOOP_EN
                        ptr_d = '0;
                        vp_d  = mem_q[0];
`else
                        mode_d = S_IDLE;
                        ptr_d  = '0;
                        vp_d   = NOTE_W'(NOTE_REST);
`endif
                    end else begin
                        ptr_d = ptr_inc;
                        vp_d  = mem_q[ptr_inc];
                    end
                end
            end
            default: begin
                mode_d = S_IDLE;
                vp_d   = NOTE_W'(NOTE_REST);
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= S_IDLE;
            count_q    <= '0;
            ptr_q      <= '0;
            vp_q       <= NOTE_W'(NOTE_REST);
            key_prev_q <= '0;
        end else begin
            mode_q     <= mode_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            vp_q       <= vp_d;
            key_prev_q <= bus.key_value;
        end
    end

    // Note buffer; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[count_q[PW-1:0]] <= bus.key_value;
    end

    assign bus.state      = (mode_q == S_PLAY);
    assign bus.value_play = vp_q;
    assign bus.rec_active = (mode_q == S_RECORD);
    assign bus.count      = count_q;
    assign bus.full       = full;

endmodule
